// File: rtl/id_alu_decode.sv
// RV32IM decode-stage ALU control plus ID/EX pipeline register.
// Decodes one instruction per cycle; every output is registered (1-cycle latency).
module id_alu_decode #(
    parameter bit         ENABLE_M       = 1'b1,
    parameter logic [4:0] ILLEGAL_SELECT = 5'b00000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] PC_IN,
    input  logic        IN_VALID,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic [4:0]  ALU_SELECT,
    output logic [1:0]  OP_A_SEL,
    output logic [1:0]  OP_B_SEL,
    output logic [31:0] IMM,
    output logic [4:0]  RD,
    output logic        REG_WRITE,
    output logic [31:0] PC_OUT,
    output logic        OUT_VALID,
    output logic        ILLEGAL
);

    localparam logic [4:0] ALU_ADD  = 5'b00000, ALU_SUB   = 5'b00001, ALU_AND    = 5'b00010,
                           ALU_OR   = 5'b00011, ALU_XOR   = 5'b00100, ALU_SLL    = 5'b00101,
                           ALU_SRL  = 5'b00110, ALU_SRA   = 5'b00111, ALU_MUL    = 5'b01000,
                           ALU_MULH = 5'b01001, ALU_MULHU = 5'b01010, ALU_MULHSU = 5'b01011,
                           ALU_DIV  = 5'b01100, ALU_DIVU  = 5'b01101, ALU_REM    = 5'b01110,
                           ALU_REMU = 5'b01111, ALU_SLT   = 5'b10000, ALU_SLTU   = 5'b10001,
                           ALU_FWD  = 5'b10010;

    localparam logic [6:0] OPC_OP   = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_LUI  = 7'b0110111, OPC_AUIPC = 7'b0010111,
                           OPC_JAL  = 7'b1101111, OPC_JALR  = 7'b1100111, OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] A_RS1 = 2'b00, A_PC  = 2'b01, A_IMM = 2'b10;
    localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;

    typedef struct packed {
        logic [4:0]  alu_sel;
        logic [1:0]  op_a;
        logic [1:0]  op_b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_write;
        logic        illegal;
    } id_ex_t;

    // funct3 map shared by OP (funct7=0) and OP-IMM
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    function automatic logic [4:0] m_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  m_alu = ALU_MUL;
            3'b001:  m_alu = ALU_MULH;
            3'b010:  m_alu = ALU_MULHSU;
            3'b011:  m_alu = ALU_MULHU;
            3'b100:  m_alu = ALU_DIV;
            3'b101:  m_alu = ALU_DIVU;
            3'b110:  m_alu = ALU_REM;
            default: m_alu = ALU_REMU;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        ill, wr;
    id_ex_t      dec, q;

    assign opcode = INSTRUCTION[6:0];
    assign f3     = INSTRUCTION[14:12];
    assign f7     = INSTRUCTION[31:25];

    assign imm_i = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
    assign imm_s = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
    assign imm_b = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                    INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
    assign imm_u = {INSTRUCTION[31:12], 12'b0};
    assign imm_j = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                    INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};

    always_comb begin
        dec    = '0;
        dec.rd = INSTRUCTION[11:7];
        ill    = 1'b0;
        wr     = 1'b0;
        case (opcode)
            OPC_OP: begin
                wr = 1'b1;
                case (f7)
                    7'b0000000: dec.alu_sel = base_alu(f3);
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec.alu_sel = ALU_SUB;
                        else if (f3 == 3'b101) dec.alu_sel = ALU_SRA;
                        else                   ill = 1'b1;
                    end
                    7'b0000001: begin
                        dec.alu_sel = m_alu(f3);
                        ill         = !ENABLE_M;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                wr          = 1'b1;
                dec.op_b    = B_IMM;
                dec.alu_sel = base_alu(f3);
                dec.imm     = imm_i;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // shift amount is zero-extended; upper imm bits pick SRL/SRA
                    dec.imm = {27'b0, INSTRUCTION[24:20]};
                    if (f3 == 3'b101 && f7 == 7'b0100000) dec.alu_sel = ALU_SRA;
                    else if (f7 != 7'b0000000)            ill = 1'b1;
                end
            end
            OPC_LOAD: begin
                wr       = 1'b1;
                dec.op_b = B_IMM;
                dec.imm  = imm_i;
            end
            OPC_STORE: begin
                dec.op_b = B_IMM;
                dec.imm  = imm_s;
            end
            OPC_LUI: begin
                wr          = 1'b1;
                dec.alu_sel = ALU_FWD;
                dec.op_a    = A_IMM;
                dec.imm     = imm_u;
            end
            OPC_AUIPC: begin
                wr       = 1'b1;
                dec.op_a = A_PC;
                dec.op_b = B_IMM;
                dec.imm  = imm_u;
            end
            OPC_JAL: begin
                wr       = 1'b1;
                dec.op_a = A_PC;
                dec.op_b = B_FOUR;
                dec.imm  = imm_j;
            end
            OPC_JALR: begin
                wr       = 1'b1;
                dec.op_a = A_PC;
                dec.op_b = B_FOUR;
                dec.imm  = imm_i;
                ill      = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm = imm_b;
                case (f3[2:1])
                    2'b00:   dec.alu_sel = ALU_SUB;
                    2'b10:   dec.alu_sel = ALU_SLT;
                    2'b11:   dec.alu_sel = ALU_SLTU;
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        if (ill) begin
            dec.alu_sel   = ILLEGAL_SELECT;
            dec.op_a      = A_RS1;
            dec.op_b      = B_RS2;
            dec.imm       = '0;
            dec.reg_write = 1'b0;
            dec.illegal   = 1'b1;
        end else begin
            dec.reg_write = wr && (dec.rd != 5'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q         <= '0;
            PC_OUT    <= '0;
            OUT_VALID <= 1'b0;
        end else if (FLUSH) begin
            OUT_VALID   <= 1'b0;
            q.reg_write <= 1'b0;
            q.illegal   <= 1'b0;
        end else if (!STALL) begin
            if (IN_VALID) begin
                q         <= dec;
                PC_OUT    <= PC_IN;
                OUT_VALID <= 1'b1;
            end else begin
                OUT_VALID   <= 1'b0;
                q.reg_write <= 1'b0;
            end
        end
    end

    assign ALU_SELECT = q.alu_sel;
    assign OP_A_SEL   = q.op_a;
    assign OP_B_SEL   = q.op_b;
    assign IMM        = q.imm;
    assign RD         = q.rd;
    assign REG_WRITE  = q.reg_write;
    assign ILLEGAL    = q.illegal;

endmodule
